// File: rtl/boot_loader_if.sv
// boot_loader_if: byte stream, CPU bus and memory bus seen by the boot loader.
interface boot_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [29:0] cpu_bus_addr;
    logic [31:0] cpu_bus_data_w;
    logic [3:0]  cpu_bus_mask_w;
    logic [29:0] mem_addr;
    logic [31:0] mem_data_w;
    logic [3:0]  mem_mask_w;
    modport slave (
        input  in_valid, in_data, cpu_bus_addr, cpu_bus_data_w, cpu_bus_mask_w,
        output in_ready, mem_addr, mem_data_w, mem_mask_w
    );
    modport master (
        output in_valid, in_data, cpu_bus_addr, cpu_bus_data_w, cpu_bus_mask_w,
        input  in_ready, mem_addr, mem_data_w, mem_mask_w
    );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: loads a length-prefixed little-endian image into memory, then hands the bus to the CPU.
module boot_loader #(
    parameter logic [29:0] BASE = 30'd0
) (
    input  logic clock,
    input  logic reset,
    input  logic boot_req,
    output logic cpu_reset,
    output logic busy,
    boot_loader_if.slave bus
);
    typedef enum logic [1:0] {LEN, DATA, WRITE, RUN} state_t;
    state_t      state, next;
    logic [1:0]  cnt;
    logic [29:0] idx, n, idx_inc;
    logic [31:0] w, shifted;
    logic        take, last, run;
    always_comb begin
        run = state == RUN;
        bus.in_ready = state == LEN || state == DATA;
        take = bus.in_ready && bus.in_valid;
        last = take && cnt == 2'd3;
        shifted = {bus.in_data, w[31:8]};
        idx_inc = idx + 30'd1;
        next = state == LEN   ? (last ? (shifted[29:0] == 30'd0 ? RUN : DATA) : LEN) :
               state == DATA  ? (last ? WRITE : DATA) :
               state == WRITE ? (idx_inc == n ? RUN : DATA) :
                                (boot_req ? LEN : RUN);
        busy = !run;
        bus.mem_addr = run ? bus.cpu_bus_addr : BASE + idx;
        bus.mem_data_w = run ? bus.cpu_bus_data_w : w;
        bus.mem_mask_w = run ? bus.cpu_bus_mask_w : (state == WRITE ? 4'hf : 4'h0);
    end
    // w doubles as the length shift register while in LEN; DATA refills all four bytes
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LEN;
            cnt <= 2'd0;
            idx <= 30'd0;
            cpu_reset <= 1'b1;
        end else begin
            state <= next;
            cpu_reset <= next != RUN;
            if (take) begin
                cnt <= cnt + 2'd1;
                w <= shifted;
            end
            if (state == LEN && last) begin
                n <= shifted[29:0];
                idx <= 30'd0;
            end
            if (state == WRITE)
                idx <= idx_inc;
            if (run && boot_req) begin
                cnt <= 2'd0;
                idx <= 30'd0;
            end
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed checks on two loaders (BASE=0 and BASE=0x100) driven in lockstep.
module tb_boot_loader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        boot_req = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h0;
    logic [29:0] cpu_addr = 30'h3ff;
    logic [31:0] cpu_data = 32'hcafef00d;
    logic [3:0]  cpu_mask = 4'hf;
    logic        cpu_reset0, cpu_reset1, busy0, busy1;
    int          vectors = 0;
    int          misses = 0;

    always #5 clock = ~clock;

    boot_loader_if b0 ();
    boot_loader_if b1 ();
    assign b0.in_valid = in_valid;
    assign b0.in_data = in_data;
    assign b0.cpu_bus_addr = cpu_addr;
    assign b0.cpu_bus_data_w = cpu_data;
    assign b0.cpu_bus_mask_w = cpu_mask;
    assign b1.in_valid = in_valid;
    assign b1.in_data = in_data;
    assign b1.cpu_bus_addr = cpu_addr;
    assign b1.cpu_bus_data_w = cpu_data;
    assign b1.cpu_bus_mask_w = cpu_mask;

    boot_loader #(.BASE(30'd0)) dut0 (
        .clock(clock), .reset(reset), .boot_req(boot_req),
        .cpu_reset(cpu_reset0), .busy(busy0), .bus(b0)
    );
    boot_loader #(.BASE(30'h100)) dut1 (
        .clock(clock), .reset(reset), .boot_req(boot_req),
        .cpu_reset(cpu_reset1), .busy(busy1), .bus(b1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            misses++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // control outputs common to both instances
    task automatic chk_ctl(input string tag, input logic rst_e, input logic rdy_e, input logic [3:0] mask_e);
        chk({tag, ".cpu_reset"}, {30'd0, cpu_reset1, cpu_reset0}, {30'd0, rst_e, rst_e});
        chk({tag, ".busy"}, {30'd0, busy1, busy0}, {30'd0, rst_e, rst_e});
        chk({tag, ".in_ready"}, {30'd0, b1.in_ready, b0.in_ready}, {30'd0, rdy_e, rdy_e});
        chk({tag, ".mask"}, {24'd0, b1.mem_mask_w, b0.mem_mask_w}, {24'd0, mask_e, mask_e});
    endtask

    task automatic chk_write(input string tag, input logic [29:0] idx, input logic [31:0] data);
        chk_ctl(tag, 1'b1, 1'b0, 4'hf);
        chk({tag, ".addr0"}, 32'(b0.mem_addr), 32'(idx));
        chk({tag, ".addr1"}, 32'(b1.mem_addr), 32'(30'h100 + idx));
        chk({tag, ".data0"}, b0.mem_data_w, data);
        chk({tag, ".data1"}, b1.mem_data_w, data);
    endtask

    // offers a byte and holds it until accepted; returns at the negedge after acceptance
    task automatic put(input logic [7:0] b);
        int k;
        in_valid = 1'b1;
        in_data = b;
        k = 0;
        while (!b0.in_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("ready_wait", {31'd0, b0.in_ready}, 32'd1);
        @(negedge clock);
    endtask

    task automatic put4(input logic [31:0] v);
        for (int i = 0; i < 4; i++) put(8'(v >> (8 * i)));
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_ctl("reset", 1'b1, 1'b1, 4'h0);

        put4(32'd2);
        chk_ctl("len_done", 1'b1, 1'b1, 4'h0);
        put4(32'h00000013);
        chk_write("write1", 30'd0, 32'h00000013);
        put4(32'h00100093);
        chk_write("write2", 30'd1, 32'h00100093);
        in_valid = 1'b0;
        cpu_mask = 4'h0;
        @(negedge clock);
        chk_ctl("run1", 1'b0, 1'b0, 4'h0);
        in_valid = 1'b1;
        in_data = 8'h55;
        @(negedge clock);
        chk_ctl("run_hold", 1'b0, 1'b0, 4'h0);
        in_valid = 1'b0;

        cpu_addr = 30'h5;
        cpu_data = 32'hdeadbeef;
        cpu_mask = 4'b0011;
        #1;
        chk("pass.addr", 32'(b0.mem_addr), 32'h5);
        chk("pass.data", b0.mem_data_w, 32'hdeadbeef);
        chk("pass.mask", {28'd0, b1.mem_mask_w}, 32'h3);

        @(negedge clock);
        cpu_mask = 4'hf;
        boot_req = 1'b1;
        #1;
        chk("reload_same.mask", {28'd0, b0.mem_mask_w}, 32'hf);
        @(negedge clock);
        boot_req = 1'b0;
        chk_ctl("reload_next", 1'b1, 1'b1, 4'h0);
        put4(32'd1);
        put4(32'hdeadbeef);
        chk_write("reload_write", 30'd0, 32'hdeadbeef);
        in_valid = 1'b0;
        @(negedge clock);
        chk_ctl("reload_run", 1'b0, 1'b0, 4'hf);

        cpu_mask = 4'h0;
        boot_req = 1'b1;
        @(negedge clock);
        boot_req = 1'b0;
        put(8'h00);
        put(8'h00);
        put(8'h00);
        chk_ctl("zero_len3", 1'b1, 1'b1, 4'h0);
        put(8'h00);
        chk_ctl("zero_run", 1'b0, 1'b0, 4'h0);
        in_valid = 1'b0;
        @(negedge clock);
        chk_ctl("zero_run2", 1'b0, 1'b0, 4'h0);

        boot_req = 1'b1;
        @(negedge clock);
        boot_req = 1'b0;
        put4(32'd2);
        put(8'haa);
        put(8'hbb);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk_ctl("mid_reset", 1'b1, 1'b1, 4'h0);
        reset = 1'b0;
        @(negedge clock);
        chk_ctl("post_reset", 1'b1, 1'b1, 4'h0);
        put4(32'd1);
        chk_ctl("fresh_len", 1'b1, 1'b1, 4'h0);
        put4(32'h11223344);
        chk_write("fresh_write", 30'd0, 32'h11223344);
        in_valid = 1'b0;
        @(negedge clock);
        chk_ctl("fresh_run", 1'b0, 1'b0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
# boot_loader

Boot loader and bus owner for the single-port word memory shared with the CPU core. After system reset it holds the CPU in reset. It receives a program image as a byte stream, packs it into little-endian 32-bit words and writes them to memory from word address BASE upward. It then releases the CPU and passes the CPU's memory bus straight through. A run-time request returns the system to load mode.

## Interface

Parameters:
- BASE, 0: word address (30-bit) of the first image word.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  byte stream valid
- in_ready  out  1  byte stream ready; a byte is consumed on a posedge with in_valid & in_ready
- in_data  in  8  byte stream data
- boot_req  in  1  re-enter load mode (honoured only in Run)
- cpu_reset  out  1  registered reset to the CPU core
- busy  out  1  high in every state except Run
- cpu_bus_addr  in  30  CPU word address
- cpu_bus_data_w  in  32  CPU write data
- cpu_bus_mask_w  in  4  CPU byte write mask
- mem_addr  out  30  memory word address
- mem_data_w  out  32  memory write data
- mem_mask_w  out  4  memory byte write mask; nonzero means write

Memory read data goes directly from memory to the CPU and does not pass through this block.

## Operation

States:
- Len: in_ready=1. Collects 4 bytes, little-endian, into word count N. N[31:30] are ignored.
  - After the 4th byte: if N[29:0]==0, go to Run; otherwise go to Data with idx=0.
- Data: in_ready=1. Collects 4 bytes into word W, little-endian: the first byte is W[7:0].
  - After the 4th byte, go to Write.
- Write: in_ready=0. Drives mem_addr=BASE+idx (mod 2^30), mem_data_w=W, mem_mask_w=4'b1111.
  - At the next edge, idx increments.
  - If idx+1==N[29:0], go to Run; otherwise go to Data.
- Run: in_ready=0. mem_addr/mem_data_w/mem_mask_w equal the cpu_bus_* inputs, combinationally.
  - boot_req=1 at an edge goes to Len and clears the byte counter and idx.

Output values outside Run:
- In Len, Data and Write, mem_mask_w=0 except during Write.
- mem_addr and mem_data_w are don't-care when mem_mask_w=0.
- CPU bus inputs are ignored in all states except Run.

Registered outputs:
- cpu_reset is a register loaded with (next_state != Run), so it is exactly 1 whenever state != Run.
- busy = (state != Run).

Counters and assembly:
- Byte counter: 2 bits, wraps 3→0, shared by Len and Data.
- idx: 30 bits.
- W is assembled in a shift/insert register and held stable through Write.

## Timing

Reset values:
- state=Len, byte counter=0, idx=0.
- cpu_reset=1, busy=1, in_ready=1 (from the first cycle after reset), mem_mask_w=0.

Latency and throughput:
- Throughput is at most one word per 5 cycles: 4 byte cycles plus 1 Write cycle.
- After the final Write cycle, the next cycle is Run with cpu_reset=0. The CPU fetches word 0 on that cycle.
- With N=0, Run starts the cycle after the 4th length byte.

Boundary conditions:
- in_valid gaps stall collection; there is no timeout.
- A byte offered during Write or Run is not consumed and must be held by the source.
- reset at any point, including mid-word: go to Len, discard the partial word and the length, assert cpu_reset.
- boot_req in Len/Data/Write is ignored.
- boot_req in Run: on the following cycle, state=Len, cpu_reset=1 and mem_mask_w=0.
  - A CPU store presented in that following cycle is dropped.
  - A CPU store presented in the same cycle as boot_req still completes.
- idx address wraps modulo 2^30 (BASE+idx); there is no overflow flag.

## Test plan

- Image load: BASE=0, bytes 02 00 00 00, 13 00 00 00, 93 00 10 00.
  - Write 1: mem_addr=0, mem_data_w=0x00000013, mem_mask_w=F.
  - Write 2: mem_addr=1, mem_data_w=0x00100093, mem_mask_w=F.
  - cpu_reset=0 and busy=0 on the cycle after the 2nd Write.
- Zero length: bytes 00 00 00 00.
  - No cycle with mem_mask_w≠0.
  - cpu_reset falls the cycle after the 4th byte; in_ready=0 thereafter.
- Backpressure: in_valid held high continuously with a new byte each accepted cycle.
  - in_ready=0 exactly on each Write cycle.
  - No byte is lost or duplicated; word n equals bytes 4n..4n+3.
- Pass-through in Run: cpu_bus_addr=0x5, cpu_bus_data_w=0xDEADBEEF, cpu_bus_mask_w=4'b0011.
  - Same cycle: mem_addr=0x5, mem_data_w=0xDEADBEEF, mem_mask_w=4'b0011.
- Reload: boot_req pulse in Run while cpu_bus_mask_w=F.
  - Next cycle: cpu_reset=1, mem_mask_w=0, in_ready=1.
  - A new 1-word image (01 00 00 00, EF BE AD DE) with BASE=0x100 writes mem_addr=0x100, mem_data_w=0xDEADBEEF.
- Reset mid-word: reset after 2 data bytes.
  - cpu_reset stays 1 and no write occurs.
  - A fresh length is required; the next image loads correctly from idx 0.
